// File: rtl/motor602_gate_monitor.sv
// motor602_gate_monitor
// Passive monitor on the six half-bridge gate drives. It flags shoot-through,
// dead-time violations and skipped commutation steps in a sticky fault, and
// reports the six-step sector, rotation direction and electrical period.
// The gate pins are registered once. Every check works on that copy, so an
// output follows a pin change by two clock edges.
module motor602_gate_monitor #(
  parameter int DEADTIME_MIN = 4,
  parameter int PERIOD_W     = 24
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                aHpI,
  input  logic                aLpI,
  input  logic                bHpI,
  input  logic                bLpI,
  input  logic                cHpI,
  input  logic                cLpI,
  input  logic                clrFaultI,
  output logic                faultO,
  output logic [1:0]          faultCodeO,
  output logic [2:0]          sectorO,
  output logic                sectorValidO,
  output logic                dirO,
  output logic [PERIOD_W-1:0] periodO,
  output logic                periodValidO
);

  typedef enum logic [1:0] {LEG_OFF, LEG_POS, LEG_NEG, LEG_SHOOT} legState_t;
  typedef enum logic [1:0] {DRV_NONE, DRV_POS, DRV_NEG} lastDrv_t;

  localparam int                 CNT_W      = $clog2(DEADTIME_MIN + 1);
  localparam logic [CNT_W-1:0]   DT_MAX     = CNT_W'(DEADTIME_MIN);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  // Registered gate copy. Index 0 = leg a, 1 = leg b, 2 = leg c.
  logic [2:0]       hQ, lQ;
  legState_t        leg [3];
  logic [CNT_W-1:0] offCnt [3];
  lastDrv_t         lastDrv [3];

  logic                shootHit, deadHit, skipHit;
  logic                secValid, stepChk, zeroEntry;
  logic [2:0]          secNow, nextP, prevP;
  logic [1:0]          newCode;
  logic                haveP, armed;
  logic [PERIOD_W-1:0] periodCnt;

  // Single register stage on the gate pins.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the pre-edge values of the others.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      hQ <= '0;
      lQ <= '0;
    end else begin
      hQ <= {cHpI, bHpI, aHpI};
      lQ <= {cLpI, bLpI, aLpI};
    end
  end

  // Decode each leg from its high/low pair.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      unique case ({hQ[i], lQ[i]})
        2'b10:   leg[i] = LEG_POS;
        2'b01:   leg[i] = LEG_NEG;
        2'b11:   leg[i] = LEG_SHOOT;
        default: leg[i] = LEG_OFF;
      endcase
    end
  end

  // Per-leg OFF run length and the polarity of the last drive.
  // NOTE: these per-leg arrays are only three entries of control state, so they are cleared by reset like any flop.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      for (int i = 0; i < 3; i++) begin
        offCnt[i]  <= '0;
        lastDrv[i] <= DRV_NONE;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (leg[i] == LEG_OFF) begin
          if (offCnt[i] != DT_MAX) offCnt[i] <= offCnt[i] + 1'b1;
        end else begin
          offCnt[i] <= '0;
        end
        if (leg[i] == LEG_POS) lastDrv[i] <= DRV_POS;
        if (leg[i] == LEG_NEG) lastDrv[i] <= DRV_NEG;
      end
    end
  end

  // Shoot-through and dead-time detection across the three legs.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shootHit = 1'b0;
    deadHit  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (leg[i] == LEG_SHOOT) shootHit = 1'b1;
      if (offCnt[i] < DT_MAX &&
          ((leg[i] == LEG_POS && lastDrv[i] == DRV_NEG) ||
           (leg[i] == LEG_NEG && lastDrv[i] == DRV_POS)))
        deadHit = 1'b1;
    end
  end

  // Six-step sector decode and step legality relative to the last valid sector.
  always_comb begin
    secValid = 1'b1;
    secNow   = 3'd0;
    case ({leg[0], leg[1], leg[2]})
      {LEG_POS, LEG_NEG, LEG_OFF}: secNow = 3'd0;
      {LEG_POS, LEG_OFF, LEG_NEG}: secNow = 3'd1;
      {LEG_OFF, LEG_POS, LEG_NEG}: secNow = 3'd2;
      {LEG_NEG, LEG_POS, LEG_OFF}: secNow = 3'd3;
      {LEG_NEG, LEG_OFF, LEG_POS}: secNow = 3'd4;
      {LEG_OFF, LEG_NEG, LEG_POS}: secNow = 3'd5;
      default:                     secValid = 1'b0;
    endcase
    nextP     = (sectorO == 3'd5) ? 3'd0 : sectorO + 3'd1;
    prevP     = (sectorO == 3'd0) ? 3'd5 : sectorO - 3'd1;
    stepChk   = secValid && haveP && (secNow != sectorO);
    skipHit   = stepChk && (secNow != nextP) && (secNow != prevP);
    zeroEntry = secValid && (secNow == 3'd0) && (!haveP || sectorO != 3'd0);
    newCode   = shootHit ? 2'd1 : (deadHit ? 2'd2 : 2'd3);
  end

  // Sector, direction and the have-a-previous-sector flag.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      sectorO      <= 3'd0;
      sectorValidO <= 1'b0;
      dirO         <= 1'b0;
      haveP        <= 1'b0;
    end else begin
      sectorValidO <= secValid;
      if (secValid) begin
        sectorO <= secNow;
        haveP   <= 1'b1;
        if (stepChk && secNow == nextP) dirO <= 1'b0;
        if (stepChk && secNow == prevP) dirO <= 1'b1;
      end
    end
  end

  // Electrical period between sector-0 entries; the first entry only arms.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      periodCnt    <= '0;
      periodO      <= '0;
      periodValidO <= 1'b0;
      armed        <= 1'b0;
    end else begin
      periodValidO <= 1'b0;
      if (zeroEntry) begin
        if (armed) begin
          periodO      <= periodCnt;
          periodValidO <= 1'b1;
        end
        periodCnt <= PERIOD_W'(1);
        armed     <= 1'b1;
      end else if (periodCnt != PERIOD_MAX) begin
        periodCnt <= periodCnt + 1'b1;
      end
    end
  end

  // Sticky fault: first code wins until cleared; a fault coincident with clear loads anew.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      faultO     <= 1'b0;
      faultCodeO <= 2'd0;
    end else if (shootHit || deadHit || skipHit) begin
      faultO <= 1'b1;
      if (!faultO || clrFaultI) faultCodeO <= newCode;
    end else if (clrFaultI) begin
      faultO     <= 1'b0;
      faultCodeO <= 2'd0;
    end
  end

endmodule
